// File: rtl/fsm_seq_driver.sv
// Initiator driver for the 4-state in1/in2/in3 handshake.
// Sequences one command per accept; reports done or err with a cause code.
module fsm_seq_driver #(
  parameter int TIMEOUT = 16,
  parameter int HOLD_W  = 4,
  parameter int TO_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_abort,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              in1,
  output logic              in2,
  output logic              in3,
  input  logic              out1,
  input  logic              out2,
  input  logic              out3,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT2,
    S_CHECK,
    S_HOLD,
    S_REL
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state;
  logic              abort_q;
  logic [HOLD_W-1:0] hold_q;
  logic [TO_W-1:0]   cnt;
  logic [TO_W-1:0]   cnt_inc;
  logic [2:0]        ack;
  logic              timed_out;
  logic              fail_now;
  logic [1:0]        fail_code;
  logic              done_now;

  assign ack       = {out1, out2, out3};
  assign timed_out = (cnt >= TO_LAST);
  assign cnt_inc   = (&cnt) ? cnt : cnt + TO_W'(1);

  // Terminal outcomes; an expected ack always beats a timeout.
  always_comb begin
    fail_now  = 1'b0;
    fail_code = 2'b00;
    done_now  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready && ack != 3'b000) begin
          fail_now  = 1'b1;
          fail_code = 2'b00;
        end
      end
      S_ARM: begin
        if (ack != 3'b100 && timed_out) begin
          fail_now  = 1'b1;
          fail_code = 2'b01;
        end
      end
      S_WAIT2: begin
        if (ack != 3'b110 && timed_out) begin
          fail_now  = 1'b1;
          fail_code = 2'b10;
        end
      end
      S_CHECK: begin
        if (abort_q && ack == 3'b000) begin
          done_now = 1'b1;
        end else if (abort_q || ack != 3'b111) begin
          fail_now  = 1'b1;
          fail_code = 2'b10;
        end
      end
      S_HOLD: begin
        if (ack != 3'b111) begin
          fail_now  = 1'b1;
          fail_code = 2'b10;
        end
      end
      S_REL: begin
        if (ack == 3'b000) begin
          done_now = 1'b1;
        end else if (timed_out) begin
          fail_now  = 1'b1;
          fail_code = 2'b11;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      in1       <= 1'b0;
      in2       <= 1'b0;
      in3       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      cnt       <= '0;
      abort_q   <= 1'b0;
      hold_q    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (fail_now) begin
        err       <= 1'b1;
        err_code  <= fail_code;
        in1       <= 1'b0;
        in2       <= 1'b0;
        in3       <= 1'b0;
        busy      <= 1'b0;
        cmd_ready <= 1'b1;
        cnt       <= '0;
        state     <= S_IDLE;
      end else if (done_now) begin
        done      <= 1'b1;
        in3       <= 1'b0;
        busy      <= 1'b0;
        cmd_ready <= 1'b1;
        cnt       <= '0;
        state     <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
              abort_q   <= cmd_abort;
              hold_q    <= cmd_hold;
              cnt       <= '0;
              in1       <= 1'b1;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
              state     <= S_ARM;
            end
          end
          S_ARM: begin
            if (ack == 3'b100) begin
              in1   <= 1'b0;
              in2   <= ~abort_q;
              cnt   <= '0;
              state <= S_WAIT2;
            end else begin
              cnt <= cnt_inc;
            end
          end
          S_WAIT2: begin
            if (ack == 3'b110) begin
              in2   <= 1'b0;
              cnt   <= '0;
              state <= S_CHECK;
            end else begin
              cnt <= cnt_inc;
            end
          end
          S_CHECK: begin
            cnt   <= '0;
            state <= S_HOLD;
          end
          S_HOLD: begin
            if (cnt == TO_W'(hold_q)) begin
              in3   <= 1'b1;
              cnt   <= '0;
              state <= S_REL;
            end else begin
              cnt <= cnt_inc;
            end
          end
          S_REL: cnt <= cnt_inc;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsm_seq_driver.sv
// Bench for fsm_seq_driver: peer FSM, sequential reference model,
// per-cycle output compare and directed scenario checks.
module tb_fsm_seq_driver;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_abort = 1'b0;
  logic [3:0] cmd_hold = 4'd0;
  logic       in1, in2, in3;
  logic       out1, out2, out3;
  logic       busy, done, err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  fsm_seq_driver #(.TIMEOUT(TIMEOUT), .HOLD_W(4), .TO_W(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_abort(cmd_abort), .cmd_hold(cmd_hold),
    .in1(in1), .in2(in2), .in3(in3),
    .out1(out1), .out2(out2), .out3(out3),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  // Peer: 4-state responder with override knobs for fault scenarios
  logic [1:0] p;
  logic       p_rst = 1'b1;
  logic       p_force = 1'b0;
  logic [2:0] p_fa = 3'b000;
  logic       p_norel = 1'b0;
  logic [2:0] p_enc;

  always @(posedge clk) begin
    if (p_rst) p <= 2'd0;
    else begin
      case (p)
        2'd0: if (in1) p <= 2'd1;
        2'd1: if (!in1) p <= 2'd2;
        2'd2: p <= in2 ? 2'd3 : 2'd0;
        default: if (in3 && !p_norel) p <= 2'd0;
      endcase
    end
  end

  always_comb begin
    p_enc = 3'b000;
    case (p)
      2'd1: p_enc = 3'b100;
      2'd2: p_enc = 3'b110;
      2'd3: p_enc = 3'b111;
      default: p_enc = 3'b000;
    endcase
  end

  assign {out1, out2, out3} = p_force ? p_fa : p_enc;

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference model: walks a command as a straight-line procedure
  logic       e_rdy = 1'b0, e_in1 = 1'b0, e_in2 = 1'b0, e_in3 = 1'b0;
  logic       e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [1:0] e_code = 2'd0;
  logic       rs, cv;
  logic [2:0] a;

  task automatic tick();
    @(posedge clk);
    e_done = 1'b0;
    e_err  = 1'b0;
    rs = rst;
    cv = cmd_valid;
    a  = {out1, out2, out3};
    if (rs) begin
      {e_in1, e_in2, e_in3, e_busy} = 4'b0000;
      e_code = 2'd0;
      e_rdy  = 1'b1;
    end
  endtask

  task automatic m_fail(input logic [1:0] c);
    e_err = 1'b1;
    e_code = c;
    {e_in1, e_in2, e_in3, e_busy} = 4'b0000;
    e_rdy = 1'b1;
  endtask

  task automatic m_done();
    e_done = 1'b1;
    {e_in1, e_in2, e_in3, e_busy} = 4'b0000;
    e_rdy = 1'b1;
  endtask

  task automatic m_wait(input logic [2:0] want, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      if (rs) return;
      if (a == want) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic model_cmd();
    logic ab;
    int   hq;
    logic ok;
    ab = cmd_abort;
    hq = int'(cmd_hold);
    if (a != 3'b000) begin m_fail(2'd0); return; end
    e_in1 = 1'b1; e_busy = 1'b1; e_rdy = 1'b0;
    m_wait(3'b100, ok);
    if (rs) return;
    if (!ok) begin m_fail(2'd1); return; end
    e_in1 = 1'b0; e_in2 = !ab;
    m_wait(3'b110, ok);
    if (rs) return;
    if (!ok) begin m_fail(2'd2); return; end
    e_in2 = 1'b0;
    tick();
    if (rs) return;
    if (ab) begin
      if (a == 3'b000) m_done();
      else m_fail(2'd2);
      return;
    end
    if (a != 3'b111) begin m_fail(2'd2); return; end
    for (int k = 0; k <= hq; k++) begin
      tick();
      if (rs) return;
      if (a != 3'b111) begin m_fail(2'd2); return; end
    end
    e_in3 = 1'b1;
    m_wait(3'b000, ok);
    if (rs) return;
    if (!ok) begin m_fail(2'd3); return; end
    m_done();
  endtask

  initial begin : model
    forever begin
      tick();
      if (!rs && cv && e_rdy) model_cmd();
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en)
      chk("cycle_outputs",
          int'({cmd_ready, in1, in2, in3, busy, done, err, err_code}),
          int'({e_rdy, e_in1, e_in2, e_in3, e_busy, e_done, e_err, e_code}));
  end

  // One command; gathers latency (edges after accept) and in* high counts
  task automatic run_cmd(input logic ab, input int hq, input int force_n,
                         input logic [2:0] fval, input int rst_at,
                         output int lat, output int c1, output int c2,
                         output int c3, output int nd, output int ne,
                         output int code);
    lat = -1; c1 = 0; c2 = 0; c3 = 0; nd = 0; ne = 0; code = -1;
    @(negedge clk);
    cmd_abort = ab;
    cmd_hold  = 4'(hq);
    cmd_valid = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      c1 += int'(in1);
      c2 += int'(in2);
      c3 += int'(in3);
      if (done) begin nd++; lat = n - 1; end
      if (err) begin ne++; lat = n - 1; code = int'(err_code); end
      if (rst_at != 0 && n == rst_at + 1) break;
      if (rst_at != 0 && n == rst_at) rst = 1'b1;
      if (n == force_n) begin p_force = 1'b1; p_fa = fval; end
      if (done || err) break;
    end
  endtask

  task automatic peer_reset();
    @(negedge clk);
    p_force = 1'b0;
    p_norel = 1'b0;
    p_rst = 1'b1;
    @(negedge clk);
    p_rst = 1'b0;
    @(negedge clk);
  endtask

  int lat, c1, c2, c3, nd, ne, code;
  int d1, d2;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_in1", int'(in1), 0);
    chk("reset_code", int'(err_code), 0);
    rst = 1'b0;
    p_rst = 1'b0;
    @(negedge clk);

    run_cmd(1'b0, 3, 0, 3'b000, 0, lat, c1, c2, c3, nd, ne, code);
    chk("norm_lat", lat, 11);
    chk("norm_done", nd, 1);
    chk("norm_err", ne, 0);
    chk("norm_in1", c1, 2);
    chk("norm_in2", c2, 2);
    chk("norm_in3", c3, 2);
    peer_reset();

    run_cmd(1'b1, 3, 0, 3'b000, 0, lat, c1, c2, c3, nd, ne, code);
    chk("abort_lat", lat, 5);
    chk("abort_done", nd, 1);
    chk("abort_in2", c2, 0);
    chk("abort_in3", c3, 0);
    peer_reset();

    p_force = 1'b1; p_fa = 3'b000;
    run_cmd(1'b0, 2, 0, 3'b000, 0, lat, c1, c2, c3, nd, ne, code);
    chk("stuck_lat", lat, 16);
    chk("stuck_code", code, 1);
    chk("stuck_in1", c1, 16);
    peer_reset();

    p_force = 1'b1; p_fa = 3'b110;
    run_cmd(1'b0, 2, 0, 3'b000, 0, lat, c1, c2, c3, nd, ne, code);
    chk("busy_peer_lat", lat, 0);
    chk("busy_peer_code", code, 0);
    chk("busy_peer_in1", c1, 0);
    peer_reset();

    run_cmd(1'b0, 5, 8, 3'b000, 0, lat, c1, c2, c3, nd, ne, code);
    chk("hold_drop_code", code, 2);
    chk("hold_drop_lat", lat, 8);
    peer_reset();

    p_norel = 1'b1;
    run_cmd(1'b0, 3, 0, 3'b000, 0, lat, c1, c2, c3, nd, ne, code);
    chk("norel_code", code, 3);
    chk("norel_lat", lat, 25);
    chk("norel_in3", c3, 16);
    peer_reset();

    run_cmd(1'b0, 8, 0, 3'b000, 8, lat, c1, c2, c3, nd, ne, code);
    chk("rst_outs", int'({in1, in2, in3, busy, done, err}), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    rst = 1'b0;
    peer_reset();
    run_cmd(1'b0, 1, 0, 3'b000, 0, lat, c1, c2, c3, nd, ne, code);
    chk("after_rst_lat", lat, 9);
    chk("after_rst_done", nd, 1);
    peer_reset();

    // Back-to-back with cmd_valid held high
    d1 = -1; d2 = -1;
    cmd_abort = 1'b0;
    cmd_hold  = 4'd0;
    cmd_valid = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done && d1 < 0) begin
        d1 = n;
        chk("b2b_in1_at_done", int'(in1), 0);
      end else if (done) begin
        d2 = n;
        cmd_valid = 1'b0;
        break;
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_first_lat", d1 - 1, 8);
    chk("b2b_gap", d2 - d1, 9);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fsm_seq_driver.md
Name: fsm_seq_driver

Overview:
- Initiator-side driver for the 4-state handshake FSM (state0→state1→state2→state3→state0).
- Accepts a one-shot command and generates the in1/in2/in3 stimulus, using the peer's level outputs out1/out2/out3 as acknowledgements.
- Supports a normal sequence with a programmable hold in state3, or an abort at state2.
- Detects timeouts and illegal acknowledgement patterns, reporting completion or error to the local controller.

Parameters:
- TIMEOUT, 16, max cycles any wait state waits for its expected ack pattern before erroring.
- HOLD_W, 4, width of cmd_hold.
- TO_W, 5, width of the timeout/hold counter; must satisfy 2^TO_W > max(TIMEOUT, 2^HOLD_W).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
- cmd_abort  in  1  sampled at accept; 1 = drive in2=0 at state2 (abort path)
- cmd_hold  in  HOLD_W  sampled at accept; cycles to dwell in state3 before releasing
- in1  out  1  to peer: start request
- in2  out  1  to peer: continue
- in3  out  1  to peer: release
- out1  in  1  from peer, ack vector bit 2
- out2  in  1  from peer, ack vector bit 1
- out3  in  1  from peer, ack vector bit 0
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion (normal or abort)
- err  out  1  one-cycle pulse on failure
- err_code  out  2  valid with err, held until next err: 00 peer not idle at start, 01 no out1 ack, 10 bad/missing state2/state3 ack, 11 release not seen

Behaviour:
- Reset: state IDLE. in1=in2=in3=0, done=err=0, err_code=00, busy=0, counter=0. Reset mid-operation drops all in* next edge; there is no completion pulse.
- All outputs are registered. Ack vector A={out1,out2,out3}: 000 = peer state0, 100 = state1, 110 = state2, 111 = state3.
- IDLE: on accept, latch cmd_abort/cmd_hold and clear the counter.
  - If A≠000: pulse err, code 00, stay IDLE.
  - Otherwise set in1=1 and go to ARM.
- ARM: when A==100, set in1=0 and in2=~abort_q, then go to WAIT2.
  - in2 is therefore stable during the peer's state2 cycle, when the peer samples it.
- WAIT2: when A==110, set in2=0, clear the counter, then go to CHECK.
- CHECK (one cycle after state2):
  - Non-abort: A==111 → HOLD (counter=0).
  - Abort: A==000 → pulse done, go to IDLE.
  - Any other A: err code 10, go to IDLE.
- HOLD: count cycles while A==111. When counter==hold_q, set in3=1 and go to REL.
  - hold_q=0 asserts in3 on the first HOLD cycle.
  - A leaving 111 during HOLD: err code 10.
- REL: when A==000, set in3=0, pulse done, go to IDLE.
- Timeout: in ARM, WAIT2 and REL, the counter increments per cycle. When it reaches TIMEOUT without the expected A:
  - Drive in1=in2=in3=0 and pulse err, then go to IDLE.
  - Codes: ARM→01, WAIT2→10, REL→11.
- Expected ack and timeout in the same cycle: the ack wins.
- done and err are never asserted together. A new command can be accepted the cycle after done/err (cmd_ready re-asserts in IDLE).
- Counter saturates; it never wraps.
- cmd_valid while busy is ignored (cmd_ready=0); the command is not queued.

Test Plan:
- Normal, hold=3, conforming peer model: in1 high exactly 2 cycles, in2 high 2 cycles overlapping the peer's state2, then 3 HOLD cycles, in3 until A=000 → done pulse once, err=0, total ≈10 cycles.
- Abort (cmd_abort=1): in2 stays 0, peer returns to 000 after state2 → done, in3 never asserted.
- Peer stuck at 000 (ignores in1), TIMEOUT=16 → err=1 with code 01 on cycle 16 after accept, in1 drops the same edge.
- Peer forced to A=110 at accept → immediate err code 00, in1 never asserted. Separately, peer jumps 111→000 during HOLD → err code 10.
- Peer holds 111 after in3 → err code 11 after 16 cycles. Separately, rst=1 during HOLD → next cycle all outputs 0 and busy=0; a new command is accepted after the peer is reset.
- Back-to-back: cmd_valid held high, hold=0 → second command accepted the cycle after the first done, with no glitch on in1.
